// File: rtl/mod_counter_pkg.sv
// Shared types for the configurable modulo counter.
// Mode encodings and a helper that folds the reserved mode into wrap.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } cnt_mode_e;

  localparam logic [1:0] MODE_RSVD = 2'b11;

  function automatic logic is_wrap(input logic [1:0] m);
    return (m == MODE_WRAP) || (m == MODE_RSVD);
  endfunction

  function automatic logic is_oneshot(input logic [1:0] m);
    return m == MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Next-step datapath for the modulo counter.
// Purely combinational: step value plus terminal flags.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] max_val,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_count,
  output logic             at_term,
  output logic             land_term
);

  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] dec;

  assign inc = count + WIDTH'(1);
  assign dec = count - WIDTH'(1);

  always_comb begin
    at_term    = 1'b0;
    land_term  = 1'b0;
    next_count = count;
    if (up) begin
      at_term = count >= max_val;
    end else begin
      at_term = count == '0;
    end
    if (!at_term) begin
      next_count = up ? inc : dec;
      land_term  = up ? (inc == max_val)
                      : (dec == '0);
    end else if (is_wrap(mode)) begin
      next_count = up ? '0 : max_val;
    end else begin
      // holding at the top also pulls an over-range load back in
      next_count = up ? max_val : count;
    end
  end

endmodule

// File: rtl/mod_counter_cfg.sv
// Configurable modulo counter: wrap, saturate and one-shot modes.
// Priority clr > load > step > hold, all outputs registered.
module mod_counter_cfg
  import mod_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] RST_CNT =
    WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] nxt;
  logic             at_term;
  logic             land_term;
  logic             step;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_d;
  logic             done_d;

  mod_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count      (count),
    .max_val    (max_val),
    .up         (up),
    .mode       (mode),
    .next_count (nxt),
    .at_term    (at_term),
    .land_term  (land_term)
  );

  assign step = en && !done;

  always_comb begin
    cnt_d  = count;
    tc_d   = 1'b0;
    done_d = done;
    if (clr) begin
      cnt_d  = RST_CNT;
      done_d = 1'b0;
    end else if (load) begin
      cnt_d  = load_val;
      done_d = 1'b0;
    end else if (step) begin
      cnt_d = nxt;
      if (is_wrap(mode)) begin
        tc_d = at_term;
      end else begin
        tc_d = land_term;
      end
      // starting at terminal finishes a one-shot without a tc
      if (is_oneshot(mode)) begin
        done_d = at_term || land_term;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_CNT;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= cnt_d;
      tc    <= tc_d;
      done  <= done_d;
    end
  end

endmodule
